// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation vector selection slice:
// candidate-count / MV-width derivation, FSM state type and MV component type.
package me_pkg;

    // Candidate positions per axis for a given search-window and macroblock edge.
    function automatic int me_npos(input int search_dim, input int macro_dim);
        return search_dim - macro_dim + 1;
    endfunction

    // Signed MV component width: enough magnitude bits for the index range plus a sign bit.
    function automatic int me_mv_w(input int search_dim, input int macro_dim);
        return $clog2(me_npos(search_dim, macro_dim)) + 1;
    endfunction

    localparam int ME_MACRO_DIM  = 16;
    localparam int ME_SEARCH_DIM = 48;
    localparam int ME_NPOS       = me_npos(ME_SEARCH_DIM, ME_MACRO_DIM);
    localparam int ME_MV_W       = me_mv_w(ME_SEARCH_DIM, ME_MACRO_DIM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } me_sel_state_t;

    typedef logic signed [ME_MV_W-1:0] mv_t;

endpackage

// File: rtl/me_raster_ctr.sv
// Raster-order (cx, cy) position counter over an NPOS x NPOS candidate grid.
// clear restarts at (0,0); advance steps cx and wraps into cy at the row end.
// Shared with the search-window fetch stage, so it carries no ME policy.
module me_raster_ctr #(
    parameter int NPOS = 33,
    parameter int CW   = $clog2(NPOS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] cx,
    output logic [CW-1:0] cy,
    output logic          last_x,
    output logic          last_y
);

    localparam logic [CW-1:0] LAST_IDX = CW'(NPOS - 1);

    logic [CW-1:0] cx_r;
    logic [CW-1:0] cy_r;

    // Position register: clear wins over advance; row end wraps cx and bumps cy.
    always_ff @(posedge clk) begin
        if (rst) begin
            cx_r <= {CW{1'b0}};
            cy_r <= {CW{1'b0}};
        end else if (clear) begin
            cx_r <= {CW{1'b0}};
            cy_r <= {CW{1'b0}};
        end else if (advance) begin
            if (cx_r == LAST_IDX) begin
                cx_r <= {CW{1'b0}};
                if (cy_r == LAST_IDX) begin
                    cy_r <= {CW{1'b0}};
                end else begin
                    cy_r <= cy_r + CW'(1);
                end
            end else begin
                cx_r <= cx_r + CW'(1);
                cy_r <= cy_r;
            end
        end else begin
            cx_r <= cx_r;
            cy_r <= cy_r;
        end
    end

    assign cx     = cx_r;
    assign cy     = cy_r;
    assign last_x = (cx_r == LAST_IDX);
    assign last_y = (cy_r == LAST_IDX);

endmodule

// File: rtl/me_mv_select.sv
// Motion-vector selector: consumes one SAD per search candidate in raster
// order, keeps the best one (zero-MV bias on ties at the centre, otherwise the
// earliest candidate wins) and presents the winning MV and SAD once per
// macroblock with a valid/ready handshake that never drops a result.
module me_mv_select
    import me_pkg::*;
#(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48,
    parameter int SAD_W      = 16
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    input  logic                                              sad_valid,
    input  logic [SAD_W-1:0]                                  sad,
    output logic                                              sad_ready,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic signed [me_mv_w(SEARCH_DIM, MACRO_DIM)-1:0]  mv_x,
    output logic signed [me_mv_w(SEARCH_DIM, MACRO_DIM)-1:0]  mv_y,
    output logic [SAD_W-1:0]                                  min_sad,
    output logic                                              err_drop
);

    localparam int NPOS = me_npos(SEARCH_DIM, MACRO_DIM);
    localparam int MV_W = me_mv_w(SEARCH_DIM, MACRO_DIM);
    localparam int CW   = MV_W - 1;

    localparam logic [CW-1:0]          CENTRE_IDX = CW'((NPOS - 1) / 2);
    localparam logic signed [MV_W-1:0] MV_OFFSET  = MV_W'((NPOS - 1) / 2);

    me_sel_state_t state_r;
    me_sel_state_t next_state_s;

    logic [CW-1:0] cx_s;
    logic [CW-1:0] cy_s;
    logic          last_x_s;
    logic          last_y_s;
    logic          last_cand_s;

    logic          accept_s;
    logic          enter_scan_s;
    logic          advance_s;
    logic          done_s;
    logic          centre_s;
    logic          replace_s;

    logic [SAD_W-1:0] best_sad_r;
    logic [CW-1:0]    best_cx_r;
    logic [CW-1:0]    best_cy_r;
    logic             first_r;

    logic [SAD_W-1:0] best_sad_nxt_s;
    logic [CW-1:0]    best_cx_nxt_s;
    logic [CW-1:0]    best_cy_nxt_s;

    logic                   sad_ready_r;
    logic                   out_valid_r;
    logic signed [MV_W-1:0] mv_x_r;
    logic signed [MV_W-1:0] mv_y_r;
    logic [SAD_W-1:0]       min_sad_r;
    logic                   err_drop_r;

    me_raster_ctr #(
        .NPOS (NPOS),
        .CW   (CW)
    ) u_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (enter_scan_s),
        .advance (advance_s),
        .cx      (cx_s),
        .cy      (cy_s),
        .last_x  (last_x_s),
        .last_y  (last_y_s)
    );

    assign last_cand_s = last_x_s & last_y_s;
    assign accept_s    = (state_r == SCAN) & sad_valid;
    // A start in SCAN aborts, so a SAD arriving with it is not a candidate.
    assign advance_s   = accept_s & ~start;
    assign done_s      = advance_s & last_cand_s;
    assign centre_s    = (cx_s == CENTRE_IDX) & (cy_s == CENTRE_IDX);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state: restart always wins in SCAN; DONE leaves only on handshake.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = SCAN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SCAN: begin
                if (start) begin
                    next_state_s = SCAN;
                end else if (done_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = SCAN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (start) begin
                        next_state_s = SCAN;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM control outputs: when a fresh search begins (IDLE start, abort, or start alongside the handshake).
    always_comb begin
        enter_scan_s = 1'b0;
        case (state_r)
            IDLE:    enter_scan_s = start;
            SCAN:    enter_scan_s = start;
            DONE:    enter_scan_s = start & out_ready;
            default: enter_scan_s = 1'b0;
        endcase
    end

    // Replace decision and next best values including the candidate on the bus this cycle.
    always_comb begin
        replace_s = first_r
                  | (sad < best_sad_r)
                  | ((sad == best_sad_r) & centre_s);
        if (accept_s & replace_s) begin
            best_sad_nxt_s = sad;
            best_cx_nxt_s  = cx_s;
            best_cy_nxt_s  = cy_s;
        end else begin
            best_sad_nxt_s = best_sad_r;
            best_cx_nxt_s  = best_cx_r;
            best_cy_nxt_s  = best_cy_r;
        end
    end

    // Running-best registers; first_r forces the (0,0) candidate in even if its SAD is all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_sad_r <= {SAD_W{1'b0}};
            best_cx_r  <= {CW{1'b0}};
            best_cy_r  <= {CW{1'b0}};
            first_r    <= 1'b0;
        end else if (enter_scan_s) begin
            best_sad_r <= {SAD_W{1'b1}};
            best_cx_r  <= {CW{1'b0}};
            best_cy_r  <= {CW{1'b0}};
            first_r    <= 1'b1;
        end else if (accept_s) begin
            best_sad_r <= best_sad_nxt_s;
            best_cx_r  <= best_cx_nxt_s;
            best_cy_r  <= best_cy_nxt_s;
            first_r    <= 1'b0;
        end else begin
            best_sad_r <= best_sad_r;
            best_cx_r  <= best_cx_r;
            best_cy_r  <= best_cy_r;
            first_r    <= first_r;
        end
    end

    // Registered outputs: handshake flags track the next state; the result is captured
    // once on the last candidate and then held; err_drop is sticky until a new search.
    always_ff @(posedge clk) begin
        if (rst) begin
            sad_ready_r <= 1'b0;
            out_valid_r <= 1'b0;
            mv_x_r      <= {MV_W{1'b0}};
            mv_y_r      <= {MV_W{1'b0}};
            min_sad_r   <= {SAD_W{1'b0}};
            err_drop_r  <= 1'b0;
        end else begin
            sad_ready_r <= (next_state_s == SCAN);
            out_valid_r <= (next_state_s == DONE);
            if (done_s) begin
                mv_x_r    <= $signed({1'b0, best_cx_nxt_s}) - MV_OFFSET;
                mv_y_r    <= $signed({1'b0, best_cy_nxt_s}) - MV_OFFSET;
                min_sad_r <= best_sad_nxt_s;
            end else begin
                mv_x_r    <= mv_x_r;
                mv_y_r    <= mv_y_r;
                min_sad_r <= min_sad_r;
            end
            if (enter_scan_s) begin
                err_drop_r <= 1'b0;
            end else if (sad_valid & (state_r != SCAN)) begin
                err_drop_r <= 1'b1;
            end else begin
                err_drop_r <= err_drop_r;
            end
        end
    end

    assign sad_ready = sad_ready_r;
    assign out_valid = out_valid_r;
    assign mv_x      = mv_x_r;
    assign mv_y      = mv_y_r;
    assign min_sad   = min_sad_r;
    assign err_drop  = err_drop_r;

endmodule

// File: tb/tb_me_mv_select.sv
// Self-checking bench for me_mv_select: directed scenarios plus randomized
// scans, each result checked against a whole-array reference selection.
module tb_me_mv_select;

    localparam int NPOS   = 33;
    localparam int NCAND  = NPOS * NPOS;
    localparam int C      = (NPOS - 1) / 2;
    localparam int CENTRE = C * NPOS + C;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              sad_valid;
    logic [15:0]       sad;
    logic              sad_ready;
    logic              out_valid;
    logic              out_ready;
    logic signed [6:0] mv_x;
    logic signed [6:0] mv_y;
    logic [15:0]       min_sad;
    logic              err_drop;

    int sads [NCAND];
    int n_checks = 0;
    int n_errors = 0;
    bit saw_ov;

    always #5 clk = ~clk;

    me_mv_select dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sad_valid (sad_valid),
        .sad       (sad),
        .sad_ready (sad_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mv_x      (mv_x),
        .mv_y      (mv_y),
        .min_sad   (min_sad),
        .err_drop  (err_drop)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference selection: global minimum; centre wins any tie, else lowest raster index.
    task automatic model(output int ex, output int ey, output int es);
        int m;
        int pick;
        m = sads[0];
        for (int i = 1; i < NCAND; i++) if (sads[i] < m) m = sads[i];
        pick = -1;
        if (sads[CENTRE] == m) pick = CENTRE;
        for (int i = 0; i < NCAND; i++) if (pick < 0 && sads[i] == m) pick = i;
        ex = (pick % NPOS) - C;
        ey = (pick / NPOS) - C;
        es = m;
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < NCAND; i++) sads[i] = v;
    endtask

    task automatic fill_random(input int lo, input int hi);
        for (int i = 0; i < NCAND; i++) sads[i] = int'($urandom_range(hi, lo));
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int from_i, input int to_i, input int gap);
        for (int i = from_i; i <= to_i; i++) begin
            sad_valid = 1'b1;
            sad       = 16'(sads[i]);
            tick();
            sad_valid = 1'b0;
            if (i == NCAND - 2) check("ov_before_last", int'(out_valid), 0);
            if (i < NCAND - 1 && out_valid) saw_ov = 1'b1;
            if (i < NCAND - 1) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    if (out_valid) saw_ov = 1'b1;
                end
            end
        end
    endtask

    task automatic full_scan(input string tag, input int gap);
        int ex, ey, es;
        saw_ov = 1'b0;
        do_start();
        check({tag, "_sad_ready"}, int'(sad_ready), 1);
        check({tag, "_err_clr"}, int'(err_drop), 0);
        feed(0, NCAND - 1, gap);
        check({tag, "_latency"}, int'(out_valid), 1);
        check({tag, "_no_early_ov"}, int'(saw_ov), 0);
        check({tag, "_ready_low"}, int'(sad_ready), 0);
        model(ex, ey, es);
        check({tag, "_mv_x"}, int'(mv_x), ex);
        check({tag, "_mv_y"}, int'(mv_y), ey);
        check({tag, "_min_sad"}, int'(min_sad), es);
    endtask

    task automatic accept_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ov_cleared"}, int'(out_valid), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sad_ready"}, int'(sad_ready), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_mv_x"}, int'(mv_x), 0);
        check({tag, "_mv_y"}, int'(mv_y), 0);
        check({tag, "_min_sad"}, int'(min_sad), 0);
        check({tag, "_err_drop"}, int'(err_drop), 0);
    endtask

    initial begin
        int sx, sy, ss;
        bit stable;

        rst       = 1'b1;
        start     = 1'b0;
        sad_valid = 1'b0;
        sad       = 16'd0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("reset");

        // sad_valid while idle is flagged, then cleared by the next start
        sad_valid = 1'b1;
        sad       = 16'd5;
        tick();
        sad_valid = 1'b0;
        check("idle_err_drop", int'(err_drop), 1);

        // 1: single minimum at cy=20, cx=5
        fill(500);
        sads[20 * NPOS + 5] = 10;
        full_scan("t1", 0);
        check("t1_const_mv_x", int'(mv_x), -11);
        check("t1_const_mv_y", int'(mv_y), 4);
        check("t1_const_sad", int'(min_sad), 10);
        accept_result("t1");

        // 2: all equal -> centre
        fill(300);
        full_scan("t2", 0);
        check("t2_const_mv_x", int'(mv_x), 0);
        check("t2_const_mv_y", int'(mv_y), 0);
        accept_result("t2");

        // 3: tie at opposite corners -> earliest
        fill(200);
        sads[0]         = 100;
        sads[NCAND - 1] = 100;
        full_scan("t3", 0);
        check("t3_const_mv_x", int'(mv_x), -16);
        check("t3_const_mv_y", int'(mv_y), -16);
        accept_result("t3");

        // 4: sparse feed, abort after 400 candidates, then full sparse scan
        fill(200);
        sads[NCAND - 1] = 7;
        saw_ov = 1'b0;
        do_start();
        feed(0, 399, 2);
        check("t4_no_ov_on_abort", int'(saw_ov), 0);
        full_scan("t4", 2);
        check("t4_const_mv_x", int'(mv_x), 16);
        check("t4_const_mv_y", int'(mv_y), 16);
        check("t4_const_sad", int'(min_sad), 7);
        accept_result("t4");
        saw_ov = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (out_valid) saw_ov = 1'b1;
        end
        check("t4_single_result", int'(saw_ov), 0);

        // 5: back-pressure with stray SADs, then handshake together with start
        fill_random(100, 900);
        full_scan("t5", 0);
        sx = int'(mv_x);
        sy = int'(mv_y);
        ss = int'(min_sad);
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            sad_valid = (k == 0) ? 1'b1 : 1'($urandom_range(1, 0));
            sad       = 16'($urandom_range(50, 0));
            start     = (k == 7) ? 1'b1 : 1'b0;
            tick();
            if (!out_valid || int'(mv_x) != sx || int'(mv_y) != sy || int'(min_sad) != ss)
                stable = 1'b0;
        end
        sad_valid = 1'b0;
        start     = 1'b0;
        check("t5_hold_stable", int'(stable), 1);
        check("t5_err_drop_set", int'(err_drop), 1);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("t5_scan_again", int'(sad_ready), 1);
        check("t5_err_drop_clr", int'(err_drop), 0);
        check("t5_ov_low", int'(out_valid), 0);

        // 6: reset mid-scan, then reset while a result is pending
        feed(0, 99, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("t6_scan_rst");
        fill_random(50, 400);
        full_scan("t6", 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("t6_done_rst");

        // randomized scans with frequent ties, centre sometimes at the minimum
        for (int r = 0; r < 4; r++) begin
            fill_random(30, 45);
            if (r[0]) sads[CENTRE] = 30;
            full_scan($sformatf("rand%0d", r), int'($urandom_range(1, 0)));
            accept_result($sformatf("rand%0d", r));
        end

        // all-ones everywhere: first candidate recorded, centre wins the tie
        fill(65535);
        full_scan("ones", 0);
        check("ones_const_sad", int'(min_sad), 65535);
        accept_result("ones");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
